// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a one-deep load buffer that commits only on frame boundaries.
// Optional leading-zero suppression on digits 3..1 when SEVENSEG_LEADING_ZERO_BLANK_EN is defined.
module sevenseg_scan_ctrl #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        system1000,
  input  logic        system1000_rstn,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  output logic [11:0] seg_out,
  output logic        frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;
  // Without a guard band the controller must never sit in BLANK, not even out of reset.
  localparam logic [0:0] ST_RESET = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  generate
    if (PRESCALE <= BLANK_CYCLES) begin : g_param_check
      $error("sevenseg_scan_ctrl: PRESCALE must exceed BLANK_CYCLES");
    end
  endgenerate

  logic [PW-1:0] presc_reg, presc_next;
  logic [1:0]    idx_reg, idx_next;
  logic [0:0]    state_reg, state_next;
  logic [15:0]   disp_reg, pend_reg;
  logic [3:0]    disp_dp_reg, pend_dp_reg;
  logic          pend_full_reg;
  logic [11:0]   seg_out_reg, seg_next;
  logic          tick_stage_reg, frame_tick_reg;
  logic          slot_wrap, frame_boundary, in_blank_next;
  logic [3:0]    nib_sel, anode_sel;
  logic          dp_sel;
  logic [6:0]    segs;

  assign slot_wrap      = (presc_reg == PRESC_LAST);
  assign frame_boundary = slot_wrap && (idx_reg == 2'd3);
  assign presc_next     = slot_wrap ? '0 : presc_reg + PW'(1);
  assign idx_next       = slot_wrap ? idx_reg + 2'd1 : idx_reg;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_next = 1'b0;
    end else begin : g_blank
      localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
      assign in_blank_next = (presc_next < BLANK_END);
    end
  endgenerate

  assign state_next = in_blank_next ? ST_BLANK : ST_SHOW;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign anode_sel[gi] = (idx_reg != 2'(gi));
    end
  endgenerate

  always_comb begin
    nib_sel = disp_reg[3:0];
    dp_sel  = disp_dp_reg[0];
    case (idx_reg)
      2'd1: begin nib_sel = disp_reg[7:4];   dp_sel = disp_dp_reg[1]; end
      2'd2: begin nib_sel = disp_reg[11:8];  dp_sel = disp_dp_reg[2]; end
      2'd3: begin nib_sel = disp_reg[15:12]; dp_sel = disp_dp_reg[3]; end
      default: ;
    endcase
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  logic lz_blank;
  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (idx_reg)
      2'd1: lz_blank = (disp_reg[15:4] == 12'h000);
      2'd2: lz_blank = (disp_reg[15:8] == 8'h00);
      2'd3: lz_blank = (disp_reg[15:12] == 4'h0);
      default: ;
    endcase
  end
`endif

  always_comb begin
    segs     = hex7(nib_sel);
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (lz_blank) segs = 7'h7F;
`endif
    seg_next = 12'hFFF;
    if (state_reg == ST_SHOW) seg_next = {anode_sel, ~dp_sel, segs};
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      presc_reg      <= '0;
      idx_reg        <= 2'd0;
      state_reg      <= ST_RESET;
      disp_reg       <= 16'h0000;
      disp_dp_reg    <= 4'h0;
      pend_reg       <= 16'h0000;
      pend_dp_reg    <= 4'h0;
      pend_full_reg  <= 1'b0;
      seg_out_reg    <= 12'hFFF;
      tick_stage_reg <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      idx_reg        <= idx_next;
      state_reg      <= state_next;
      seg_out_reg    <= seg_next;
      // frame_tick lands on the first cycle seg_out shows the newly committed frame.
      tick_stage_reg <= frame_boundary;
      frame_tick_reg <= tick_stage_reg;
      if (frame_boundary && pend_full_reg) begin
        disp_reg      <= pend_reg;
        disp_dp_reg   <= pend_dp_reg;
        pend_full_reg <= 1'b0;
      end else if (load_valid && !pend_full_reg) begin
        pend_reg      <= load_data;
        pend_dp_reg   <= load_dp;
        pend_full_reg <= 1'b1;
      end
    end
  end

  assign load_ready = ~pend_full_reg;
  assign seg_out    = seg_out_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: two instances (BLANK_CYCLES=2 and 0) against an arithmetic model of slot timing and load buffering.
module tb_sevenseg_scan_ctrl;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * P;
  localparam logic [6:0] HEX_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic [3:0]  load_dp = 4'h0;
  logic        ready_a, ready_b, tick_a, tick_b;
  logic [11:0] seg_a, seg_b;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut_a (
    .system1000(clk), .system1000_rstn(rstn), .load_valid(load_valid), .load_ready(ready_a),
    .load_data(load_data), .load_dp(load_dp), .seg_out(seg_a), .frame_tick(tick_a));

  sevenseg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(0)) dut_b (
    .system1000(clk), .system1000_rstn(rstn), .load_valid(load_valid), .load_ready(ready_b),
    .load_data(load_data), .load_dp(load_dp), .seg_out(seg_b), .frame_tick(tick_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output after k edges since reset: slot position and digit follow from k by division.
  function automatic logic [11:0] model_seg(input int k, input int blank, input logic [15:0] d,
                                            input logic [3:0] p);
    int pos;
    int dig;
    logic [6:0] segs;
    logic [3:0] an;
    pos = k % P;
    dig = (k / P) % 4;
    if (pos < blank) return 12'hFFF;
    segs = HEX_TAB[d[dig*4 +: 4]];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (dig > 0 && (d >> (dig * 4)) == 16'h0000) segs = 7'h7F;
`endif
    an = ~(4'b0001 << dig);
    return {an, ~p[dig], segs};
  endfunction

  int          m_k = 0;
  logic [15:0] m_disp = 16'h0000, m_pend = 16'h0000;
  logic [3:0]  m_dp = 4'h0, m_pend_dp = 4'h0;
  logic        m_full = 1'b0;
  logic [11:0] exp_a = 12'hFFF, exp_b = 12'hFFF;
  logic        exp_tick = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_k <= 0; m_disp <= 16'h0000; m_dp <= 4'h0; m_full <= 1'b0;
      exp_a <= 12'hFFF; exp_b <= 12'hFFF; exp_tick <= 1'b0;
    end else begin
      exp_a    <= model_seg(m_k, B, m_disp, m_dp);
      exp_b    <= model_seg(m_k, 0, m_disp, m_dp);
      exp_tick <= (m_k > 0) && (m_k % FRAME == 0);
      if ((m_k + 1) % FRAME == 0 && m_full) begin
        m_disp <= m_pend; m_dp <= m_pend_dp; m_full <= 1'b0;
      end else if (load_valid && !m_full) begin
        m_pend <= load_data; m_pend_dp <= load_dp; m_full <= 1'b1;
      end
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    check("seg_a", 32'(seg_a), 32'(exp_a));
    check("seg_b", 32'(seg_b), 32'(exp_b));
    check("ready_a", 32'(ready_a), 32'(!m_full));
    check("ready_b", 32'(ready_b), 32'(!m_full));
    check("tick_a", 32'(tick_a), 32'(exp_tick));
    check("tick_b", 32'(tick_b), 32'(exp_tick));
  end

  task automatic wait_mod(input int t);
    int n;
    n = 0;
    @(negedge clk);
    while (m_k % FRAME != t && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (m_k % FRAME != t) check("wait_mod_timeout", 32'(m_k % FRAME), 32'(t));
  endtask

  task automatic wait_anodes(input logic [3:0] an);
    int n;
    n = 0;
    @(negedge clk);
    while (seg_a[11:8] !== an && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (seg_a[11:8] !== an) check("wait_anodes_timeout", 32'(seg_a[11:8]), 32'(an));
  endtask

  task automatic wait_ready(output int k_at);
    int n;
    n = 0;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_a) check("wait_ready_timeout", 32'(ready_a), 32'd1);
    k_at = m_k;
  endtask

  initial begin
    int k0;
    int k1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg_a), 32'h0000_0FFF);
    check("reset_ready", 32'(ready_a), 32'd1);
    check("reset_tick", 32'(tick_a), 32'd0);
    #2 rstn = 1'b1;

    repeat (40) @(negedge clk);
    wait_anodes(4'hE);
    check("idle_digit0", 32'(seg_a), 32'h0000_0EC0);
    wait_mod(1);
    check("blank_slot_start", 32'(seg_a), 32'h0000_0FFF);
    check("noblank_slot_start", 32'(seg_b), 32'h0000_0EC0);
    check("frame_tick_pulse", 32'(tick_a), 32'd1);

    // Mid-frame load; a second offer while pending is full must be dropped.
    wait_mod(10);
    load_valid = 1'b1; load_data = 16'h1A8F; load_dp = 4'b0001;
    @(negedge clk);
    check("pending_ready_low", 32'(ready_a), 32'd0);
    load_data = 16'hFFFF; load_dp = 4'hF;
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    wait_ready(k1);
    check("ready_at_boundary", 32'(k1 % FRAME), 32'd0);
    wait_anodes(4'hE);
    check("load_digit0", 32'(seg_a), 32'h0000_0E0E);
    wait_anodes(4'hD);
    check("load_digit1", 32'(seg_a), 32'h0000_0D80);
    wait_anodes(4'hB);
    check("load_digit2", 32'(seg_a), 32'h0000_0B88);
    wait_anodes(4'h7);
    check("load_digit3", 32'(seg_a), 32'h0000_07F9);

    // Transfer on the boundary edge commits one full frame later.
    wait_mod(FRAME - 1);
    load_valid = 1'b1; load_data = 16'h0050; load_dp = 4'h0;
    @(negedge clk);
    load_valid = 1'b0;
    k0 = m_k;
    check("boundary_ready_low", 32'(ready_a), 32'd0);
    wait_anodes(4'hE);
    check("boundary_old_digit0", 32'(seg_a), 32'h0000_0E0E);
    wait_ready(k1);
    check("boundary_latency", 32'(k1 - k0), 32'(FRAME));
    wait_anodes(4'hD);
    check("boundary_new_digit1", 32'(seg_a), 32'h0000_0D92);

    // Reset in the middle of a SHOW slot with a value pending.
    wait_mod(10);
    load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'hF;
    @(negedge clk);
    load_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("async_reset_seg", 32'(seg_a), 32'h0000_0FFF);
    check("async_reset_ready", 32'(ready_a), 32'd1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    wait_anodes(4'hE);
    check("reset_display_cleared", 32'(seg_a), 32'h0000_0EC0);
    repeat (40) @(negedge clk);
    wait_mod(5);
    check("reset_no_late_commit", 32'(seg_a), 32'h0000_0EC0);

    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      load_dp    = 4'($urandom);
      if (i == 350) begin
        #($urandom_range(1, 4)) rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
      end
    end
    load_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
